// File: rtl/div_iter_unit_pkg.sv
`default_nettype none
// ============================================================================
// div_defs : shared encodings for the iterative divider and the EX/ID/ctrl
//            stages that issue DIV/DIVU.
// Rev 1.0
// ============================================================================
package div_defs;

  localparam int DIV_STATE_W = 2;

  localparam logic [DIV_STATE_W-1:0] DivFree   = 2'b00;
  localparam logic [DIV_STATE_W-1:0] DivByZero = 2'b01;
  localparam logic [DIV_STATE_W-1:0] DivOn     = 2'b10;
  localparam logic [DIV_STATE_W-1:0] DivEnd    = 2'b11;

  localparam logic DivStart = 1'b1;
  localparam logic DivStop  = 1'b0;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  localparam int ALUOP_W = 8;

  localparam logic [ALUOP_W-1:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [ALUOP_W-1:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage : div_defs
`default_nettype wire

// File: rtl/div_iter_unit.sv
`default_nettype none
// ============================================================================
// div_iter_unit : WIDTH-generic restoring divider, one quotient bit per cycle,
//                 DIV/DIVU with truncating (C-style) signed semantics.
// Rev 1.0
// ============================================================================
module div_iter_unit
  import div_defs::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 annul_i,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o
);

  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(WIDTH);

  logic [DIV_STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]       quo_q, quo_d;
  logic [WIDTH-1:0]       rem_q, rem_d;
  logic [WIDTH-1:0]       dvs_q, dvs_d;
  logic                   sgn_quo_q, sgn_quo_d;
  logic                   sgn_rem_q, sgn_rem_d;
  logic [2*WIDTH-1:0]     result_q, result_d;
  logic                   ready_q, ready_d;

  logic                   accept;
  logic                   divisor_zero;
  logic                   neg1, neg2;
  logic [WIDTH-1:0]       abs1, abs2;
  logic [WIDTH:0]         rem_shift;
  logic [WIDTH:0]         trial;
  logic [WIDTH-1:0]       quo_fin, rem_fin;
  logic                   leave_end;

  assign accept       = (start_i == DivStart) && !annul_i;
  assign divisor_zero = (opdata2_i == '0);
  assign leave_end    = (start_i == DivStop) || annul_i;

  // MIN has no positive counterpart, but its unsigned magnitude is exact.
  assign neg1 = signed_div_i && opdata1_i[WIDTH-1];
  assign neg2 = signed_div_i && opdata2_i[WIDTH-1];
  assign abs1 = neg1 ? (~opdata1_i + 1'b1) : opdata1_i;
  assign abs2 = neg2 ? (~opdata2_i + 1'b1) : opdata2_i;

  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign trial     = rem_shift - {1'b0, dvs_q};

  assign quo_fin = sgn_quo_q ? (~quo_q + 1'b1) : quo_q;
  assign rem_fin = sgn_rem_q ? (~rem_q + 1'b1) : rem_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DivFree;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DivFree: begin
        if (accept) begin
          state_d = divisor_zero ? DivByZero : DivOn;
        end
      end
      DivByZero: state_d = DivEnd;
      DivOn: begin
        if (annul_i) begin
          state_d = DivFree;
        end else if (cnt_q == CNT_DONE) begin
          state_d = DivEnd;
        end
      end
      DivEnd: begin
        if (leave_end) begin
          state_d = DivFree;
        end
      end
      default: state_d = DivFree;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    sgn_quo_d = sgn_quo_q;
    sgn_rem_d = sgn_rem_q;
    result_d  = result_q;
    ready_d   = ready_q;
    case (state_q)
      DivFree: begin
        result_d = '0;
        ready_d  = DivResultNotReady;
        if (accept && !divisor_zero) begin
          quo_d     = abs1;
          dvs_d     = abs2;
          rem_d     = '0;
          cnt_d     = '0;
          sgn_quo_d = neg1 ^ neg2;
          sgn_rem_d = neg1;
        end
      end
      DivByZero: begin
        result_d = '0;
        ready_d  = DivResultReady;
      end
      DivOn: begin
        if (annul_i) begin
          cnt_d   = '0;
          ready_d = DivResultNotReady;
        end else if (cnt_q != CNT_DONE) begin
          // Negative trial (MSB set) means the divisor did not fit: restore.
          if (!trial[WIDTH]) begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = rem_shift[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          result_d = {rem_fin, quo_fin};
          ready_d  = DivResultReady;
        end
      end
      DivEnd: begin
        if (leave_end) begin
          result_d = '0;
          ready_d  = DivResultNotReady;
        end
      end
      default: begin
        result_d = '0;
        ready_d  = DivResultNotReady;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      sgn_quo_q <= 1'b0;
      sgn_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= DivResultNotReady;
    end else begin
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      sgn_quo_q <= sgn_quo_d;
      sgn_rem_q <= sgn_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule : div_iter_unit
`default_nettype wire

// File: tb/tb_div_iter_unit.sv
`default_nettype none
// ============================================================================
// tb_div_iter_unit : directed checks of div_iter_unit at WIDTH=32 and WIDTH=8.
// Rev 1.0
// ============================================================================
module tb_div_iter_unit;

  logic        clk = 1'b0;
  logic        rst;

  logic        start32, annul32, sgn32;
  logic [31:0] a32, b32;
  logic [63:0] res32;
  logic        rdy32;

  logic        start8, annul8, sgn8;
  logic [7:0]  a8, b8;
  logic [15:0] res8;
  logic        rdy8;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  div_iter_unit #(.WIDTH(32)) u_dut32 (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start32),
    .annul_i      (annul32),
    .signed_div_i (sgn32),
    .opdata1_i    (a32),
    .opdata2_i    (b32),
    .result_o     (res32),
    .ready_o      (rdy32)
  );

  div_iter_unit #(.WIDTH(8)) u_dut8 (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start8),
    .annul_i      (annul8),
    .signed_div_i (sgn8),
    .opdata1_i    (a8),
    .opdata2_i    (b8),
    .result_o     (res8),
    .ready_o      (rdy8)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one divide, measure latency, check hold-while-start and clear-after-drop.
  task automatic do_div32(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int lat);
    int n;
    @(negedge clk);
    sgn32 = sgn; a32 = a; b32 = b; start32 = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!rdy32 && n < 200);
    check_eq({tag, "_lat"}, 64'(n), 64'(lat));
    check_eq({tag, "_res"}, res32, exp);
    @(negedge clk);
    a32 = ~a; b32 = b + 32'd1; sgn32 = ~sgn;
    @(posedge clk); #1;
    check_eq({tag, "_hold_rdy"}, 64'(rdy32), 64'd1);
    check_eq({tag, "_hold_res"}, res32, exp);
    @(negedge clk);
    start32 = 1'b0;
    @(posedge clk); #1;
    check_eq({tag, "_drop_rdy"}, 64'(rdy32), 64'd0);
    check_eq({tag, "_drop_res"}, res32, 64'd0);
  endtask

  task automatic do_div8(input string tag, input logic sgn, input logic [7:0] a,
                         input logic [7:0] b, input logic [15:0] exp, input int lat);
    int n;
    @(negedge clk);
    sgn8 = sgn; a8 = a; b8 = b; start8 = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!rdy8 && n < 100);
    check_eq({tag, "_lat"}, 64'(n), 64'(lat));
    check_eq({tag, "_res"}, 64'(res8), 64'(exp));
    @(negedge clk);
    start8 = 1'b0;
    @(posedge clk); #1;
    check_eq({tag, "_drop_rdy"}, 64'(rdy8), 64'd0);
    check_eq({tag, "_drop_res"}, 64'(res8), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b0;
    start32 = 1'b0; annul32 = 1'b0; sgn32 = 1'b0; a32 = '0; b32 = '0;
    start8  = 1'b0; annul8  = 1'b0; sgn8  = 1'b0; a8  = '0; b8  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_rdy32", 64'(rdy32), 64'd0);
    check_eq("reset_res32", res32, 64'd0);
    check_eq("reset_rdy8",  64'(rdy8),  64'd0);
    @(negedge clk);
    rst = 1'b1;

    do_div32("u100_7",     1'b0, 32'd100,      32'd7,        {32'd2,        32'd14},       34);
    do_div32("s-7_2",      1'b1, 32'hFFFFFFF9, 32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}, 34);
    do_div32("s7_-2",      1'b1, 32'd7,        32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, 34);
    do_div32("s-100_7",    1'b1, 32'hFFFFFF9C, 32'd7,        {32'hFFFFFFFE, 32'hFFFFFFF2}, 34);
    do_div32("u_by0",      1'b0, 32'd12345,    32'd0,        64'd0,                        2);
    do_div32("s_by0",      1'b1, 32'h80000000, 32'd0,        64'd0,                        2);
    do_div32("smin_-1",    1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0,        32'h80000000}, 34);
    do_div32("umax_1",     1'b0, 32'hFFFFFFFF, 32'd1,        {32'd0,        32'hFFFFFFFF}, 34);
    do_div32("umax_16",    1'b0, 32'hFFFFFFFF, 32'd16,       {32'hF,        32'h0FFFFFFF}, 34);
    do_div32("s-1_-1",     1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'd0,        32'd1},        34);
    do_div32("zero_5",     1'b1, 32'd0,        32'd5,        64'd0,                        34);

    // Flush a divide at edge 10, then immediately start another.
    @(negedge clk);
    sgn32 = 1'b0; a32 = 32'd1000; b32 = 32'd3; start32 = 1'b1;
    repeat (9) @(posedge clk);
    @(negedge clk);
    annul32 = 1'b1; start32 = 1'b0;
    @(posedge clk); #1;
    check_eq("annul_rdy", 64'(rdy32), 64'd0);
    annul32 = 1'b0;
    do_div32("after_annul", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 34);

    // Asynchronous reset between edges, mid-divide.
    @(negedge clk);
    sgn32 = 1'b0; a32 = 32'd100; b32 = 32'd7; start32 = 1'b1;
    repeat (14) @(posedge clk);
    #2; rst = 1'b0; #1;
    check_eq("rst_on_rdy", 64'(rdy32), 64'd0);
    check_eq("rst_on_res", res32, 64'd0);
    @(negedge clk);
    start32 = 1'b0; rst = 1'b1;

    // Asynchronous reset while a result is being held.
    @(negedge clk);
    sgn32 = 1'b0; a32 = 32'd50; b32 = 32'd6; start32 = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!rdy32 && n < 200);
    check_eq("rst_end_pre_res", res32, {32'd2, 32'd8});
    #2; rst = 1'b0; #1;
    check_eq("rst_end_rdy", 64'(rdy32), 64'd0);
    check_eq("rst_end_res", res32, 64'd0);
    @(negedge clk);
    start32 = 1'b0; rst = 1'b1;
    do_div32("after_rst", 1'b0, 32'd1000, 32'd10, {32'd0, 32'd100}, 34);

    do_div8("w8_200_13",  1'b0, 8'd200, 8'd13, {8'd5,  8'd15},  10);
    do_div8("w8_min_-1",  1'b1, 8'h80,  8'hFF, {8'd0,  8'h80},  10);
    do_div8("w8_s-7_2",   1'b1, 8'hF9,  8'h02, {8'hFF, 8'hFD},  10);
    do_div8("w8_by0",     1'b0, 8'd77,  8'd0,  16'd0,           2);
    do_div8("w8_255_255", 1'b0, 8'hFF,  8'hFF, {8'd0,  8'd1},   10);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_div_iter_unit
`default_nettype wire

// File: doc/div_iter_unit.md
Name: div_iter_unit

Overview:
- Parametrised multi-cycle restoring divider for the EX stage. It is the multi-cycle companion to the existing MADD/MSUB cnt/hilo_temp path.
- Serves DIV/DIVU. EX drives start and operands, and holds stallreq while ready_o is low.
- Writes quotient to LO and remainder to HI through the existing whilo path.
- Width is generic, so the same unit serves 32-bit and 64-bit datapaths.

Parameters:
- WIDTH, 32, operand width in bits. Quotient and remainder are each WIDTH bits. Must be >= 2.
- CNT_W, $clog2(WIDTH+1), width of the iteration counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (0 = reset)
- start_i  input  1  request division. Held high by EX until ready_o is seen.
- annul_i  input  1  abort the in-flight division (pipeline flush)
- signed_div_i  input  1  1 = DIV (two's complement), 0 = DIVU
- opdata1_i  input  WIDTH  dividend, sampled only in FREE when start_i is accepted
- opdata2_i  input  WIDTH  divisor, sampled only in FREE when start_i is accepted
- result_o  output  2*WIDTH  {remainder, quotient}, registered
- ready_o  output  1  result_o valid, registered

Behaviour:
- Reset (rst=0, async): state=FREE, cnt=0, result_o=0, ready_o=0, internal dividend/divisor registers 0. Reset takes effect immediately, including mid-operation.
- States: FREE, BYZERO, ON, END (2-bit encoding).
- FREE:
  - If start_i=1, annul_i=0 and divisor==0: go to BYZERO.
  - If start_i=1, annul_i=0 and divisor!=0: go to ON and load the operands. When signed_div_i=1, load absolute values and latch sign_q = sign1 XOR sign2 and sign_r = sign1. Set cnt=0 and the partial remainder to 0.
  - Otherwise stay in FREE with ready_o=0 and result_o=0.
- BYZERO: the next edge goes to END with result_o=0 and ready_o=1. The unit raises no exception.
- ON:
  - If annul_i=1: go to FREE next edge, clear cnt, ready_o stays 0, no result.
  - If cnt<WIDTH: perform one restoring step. Shift {rem, quo} left by 1, trial-subtract the divisor from the upper WIDTH+1 bits, keep the result if it is non-negative and set the quotient LSB to 1, else restore. Then cnt++.
  - If cnt==WIDTH: apply signs. Negate the quotient if sign_q, and negate the remainder if sign_r. Latch result_o, set ready_o=1, go to END.
- END:
  - Hold result_o and ready_o while start_i=1.
  - When start_i=0: go to FREE next edge, ready_o=0, result_o=0.
  - annul_i in END behaves as start_i=0.
- Latency, counting the edge that accepts start_i as edge 1:
  - Nonzero divisor: ready_o is high after edge WIDTH+2, i.e. 34 for WIDTH=32.
  - Zero divisor: ready_o is high after edge 2.
- Arithmetic rules:
  - Results are truncated to WIDTH bits.
  - Signed MIN/-1 gives quotient = MIN (wrap), remainder = 0.
  - A zero dividend gives 0/0 results.
  - Unsigned and signed results match C truncating division.
- Operand changes after acceptance are ignored.
- start_i rising while in ON has no effect.
- A new start is only accepted after a FREE cycle, so back-to-back divides cost at least one idle cycle.

Decomposition:
- Shared package div_defs holds:
  - state encodings DivFree, DivByZero, DivOn, DivEnd;
  - DivStart/DivStop and DivResultReady/DivResultNotReady constants;
  - DIV/DIVU aluop codes, so id/ex/ctrl reuse them.
- No sub-module. The step, absolute-value and negate logic stay inline. A separate step block adds ports without reuse.

Test Plan:
- Unsigned 100/7, WIDTH=32 -> after 34 edges ready_o=1, result_o={32'd2, 32'd14}. Held until start_i drops, then 0 one edge later.
- Signed -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7/-2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- Divisor 0 with any dividend -> ready_o=1 after edge 2, result_o=0.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0. Unsigned 0xFFFFFFFF/1 -> quotient 0xFFFFFFFF, remainder 0.
- annul_i pulsed at edge 10 of a divide -> FREE next edge, ready_o never rises. An immediate new 9/3 gives {0, 3} at edge 34.
- rst driven low at edge 15, between clock edges -> result_o=0, ready_o=0, state FREE without waiting for a clock. Repeat with WIDTH=8: 200/13 -> {8'd5, 8'd15} after 10 edges.
